// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and parameter legality checks for the BCD modulus counter.
package bcd_mod_counter_pkg;

    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 4;

    function automatic int unsigned pow10(input int unsigned d);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < d; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    function automatic bit digits_legal(input int unsigned d);
        return (d >= 1) && (d <= MAX_DIGITS);
    endfunction

    function automatic bit modulus_legal(input int unsigned d, input int unsigned m);
        return (m >= 2) && (m <= pow10(d));
    endfunction

    // Binary to packed BCD, up to four digits.
    function automatic logic [15:0] to_bcd16(input int unsigned v);
        logic [15:0] r;
        int unsigned rem;
        r   = '0;
        rem = v;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            r[i*NIBBLE_W +: NIBBLE_W] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD digit: steps when enabled and its carry-in is set, ripples carry/borrow out.
module bcd_digit
    import bcd_mod_counter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_val,
    input  logic                i_step,
    input  logic                i_dir,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_next_c,
    output logic                o_cout_c
);

    logic at_nine;
    logic at_zero;
    logic active;

    assign at_nine = (i_val == NIBBLE_W'(BCD_MAX));
    assign at_zero = (i_val == '0);
    assign active  = i_step & i_cin;

    always_comb begin
        o_next_c = i_val;
        o_cout_c = 1'b0;
        if (active) begin
            if (i_dir) begin
                o_next_c = at_nine ? '0 : i_val + NIBBLE_W'(1);
                o_cout_c = at_nine;
            end else begin
                o_next_c = at_zero ? NIBBLE_W'(BCD_MAX) : i_val - NIBBLE_W'(1);
                o_cout_c = at_zero;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with arbitrary modulus, load validation and cascade carry.
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MODULUS = 60
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_en,
    input  logic                         i_up,
    input  logic                         i_clr,
    input  logic                         i_load,
    input  logic [NIBBLE_W*DIGITS-1:0]   i_load_val,
    output logic [NIBBLE_W*DIGITS-1:0]   o_q,
    output logic                         o_tc,
    output logic                         o_load_err
);

    localparam int unsigned W = NIBBLE_W * DIGITS;
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd16(MODULUS - 1));

    if (!digits_legal(DIGITS)) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS out of range 1..4");
    end
    if (!modulus_legal(DIGITS, MODULUS)) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS out of range 2..10^DIGITS");
    end

    logic [W-1:0]      q_q, q_d;
    logic              err_q, err_d;
    logic [W-1:0]      step_val;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] nib_ok;
    logic              unused_carry_msb;
    logic              at_max;
    logic              at_zero;
    logic              load_ok;

    assign carry[0]         = 1'b1;
    assign unused_carry_msb = carry[DIGITS];

    // Plain decimal step; modulus wrap is overridden below.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_val    (q_q[g*NIBBLE_W +: NIBBLE_W]),
            .i_step   (i_en),
            .i_dir    (i_up),
            .i_cin    (carry[g]),
            .o_next_c (step_val[g*NIBBLE_W +: NIBBLE_W]),
            .o_cout_c (carry[g+1])
        );
        assign nib_ok[g] = (i_load_val[g*NIBBLE_W +: NIBBLE_W] <= NIBBLE_W'(BCD_MAX));
    end

    // With every nibble in 0..9, packed BCD order matches decimal order.
    assign at_max  = (q_q == MAX_BCD);
    assign at_zero = (q_q == '0);
    assign load_ok = (&nib_ok) && (i_load_val <= MAX_BCD);

    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (i_clr) begin
            q_d = '0;
        end else if (i_load) begin
            if (load_ok) begin
                q_d = i_load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (i_en) begin
            if (i_up && at_max) begin
                q_d = '0;
            end else if (!i_up && at_zero) begin
                q_d = MAX_BCD;
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    // Combinational so a cascaded stage steps on the same edge this one wraps.
    assign o_tc       = i_en & ~i_clr & ~i_load & (i_up ? at_max : at_zero);
    assign o_q        = q_q;
    assign o_load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: vector table on a mod-60 instance plus multi-cycle sequences.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Mod-60, 2 digits
    logic a_en, a_up, a_clr, a_load, a_tc, a_err;
    logic [7:0] a_lv, a_q;
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a (
        .i_clk(clk), .i_reset(rst_n), .i_en(a_en), .i_up(a_up), .i_clr(a_clr),
        .i_load(a_load), .i_load_val(a_lv), .o_q(a_q), .o_tc(a_tc), .o_load_err(a_err));

    // Mod-24, 2 digits
    logic b_en, b_up, b_clr, b_load, b_tc, b_err;
    logic [7:0] b_lv, b_q;
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_b (
        .i_clk(clk), .i_reset(rst_n), .i_en(b_en), .i_up(b_up), .i_clr(b_clr),
        .i_load(b_load), .i_load_val(b_lv), .o_q(b_q), .o_tc(b_tc), .o_load_err(b_err));

    // Mod-1000, 3 digits
    logic c_en, c_up, c_clr, c_load, c_tc, c_err;
    logic [11:0] c_lv, c_q;
    bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_c (
        .i_clk(clk), .i_reset(rst_n), .i_en(c_en), .i_up(c_up), .i_clr(c_clr),
        .i_load(c_load), .i_load_val(c_lv), .o_q(c_q), .o_tc(c_tc), .o_load_err(c_err));

    // Cascaded pair: low stage's o_tc enables the high stage
    logic l_en, l_up, l_clr, l_load, l_tc, l_err;
    logic [7:0] l_lv, l_q;
    logic h_clr, h_load, h_tc, h_err;
    logic [7:0] h_lv, h_q;
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_lo (
        .i_clk(clk), .i_reset(rst_n), .i_en(l_en), .i_up(l_up), .i_clr(l_clr),
        .i_load(l_load), .i_load_val(l_lv), .o_q(l_q), .o_tc(l_tc), .o_load_err(l_err));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_hi (
        .i_clk(clk), .i_reset(rst_n), .i_en(l_tc), .i_up(l_up), .i_clr(h_clr),
        .i_load(h_load), .i_load_val(h_lv), .o_q(h_q), .o_tc(h_tc), .o_load_err(h_err));

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [7:0] lv;
        logic [7:0] q;
        logic       err;
        logic       tc;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic clr, input logic load, input logic en, input logic up,
                                input logic [7:0] lv, input logic [7:0] q, input logic err,
                                input logic tc);
        vec_t v;
        v.clr = clr; v.load = load; v.en = en; v.up = up;
        v.lv = lv; v.q = q; v.err = err; v.tc = tc;
        return v;
    endfunction

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int rem;
        rem = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;

        // clr load en up lv -> q err tc
        vecs[0]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 8'h5A, 8'h00, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        vecs[3]  = mk(0, 1, 0, 1, 8'h60, 8'h00, 1, 0);
        vecs[4]  = mk(0, 1, 0, 1, 8'h45, 8'h45, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1, 8'h00, 8'h46, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 8'h00, 8'h45, 0, 0);
        vecs[7]  = mk(0, 1, 0, 1, 8'h59, 8'h59, 0, 0);
        vecs[8]  = mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 1);
        vecs[9]  = mk(0, 0, 1, 0, 8'h00, 8'h59, 0, 1);
        vecs[10] = mk(1, 1, 1, 1, 8'h10, 8'h00, 0, 0);
        vecs[11] = mk(0, 1, 0, 1, 8'h09, 8'h09, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 8'h00, 8'h10, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 8'h00, 8'h09, 0, 0);
        vecs[14] = mk(0, 1, 1, 1, 8'h0F, 8'h09, 1, 0);
        vecs[15] = mk(0, 1, 1, 1, 8'h30, 8'h30, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 8'h00, 8'h30, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0);

        {a_en, a_up, a_clr, a_load, a_lv} = '0;
        {b_en, b_up, b_clr, b_load, b_lv} = '0;
        {c_en, c_up, c_clr, c_load, c_lv} = '0;
        {l_en, l_up, l_clr, l_load, l_lv} = '0;
        {h_clr, h_load, h_lv} = '0;

        rst_n = 1'b0;
        #1;
        chk("reset_a_q", 16'(a_q), 16'h0000);
        chk("reset_a_err", 16'(a_err), 16'h0000);
        chk("reset_c_q", 16'(c_q), 16'h0000);
        tick();
        rst_n = 1'b1;

        // Vector table on mod-60 instance
        for (int i = 0; i < NVEC; i++) begin
            a_clr = vecs[i].clr; a_load = vecs[i].load; a_en = vecs[i].en;
            a_up = vecs[i].up; a_lv = vecs[i].lv;
            #1;
            chk($sformatf("vec%0d_tc", i), 16'(a_tc), 16'(vecs[i].tc));
            tick();
            chk($sformatf("vec%0d_q", i), 16'(a_q), 16'(vecs[i].q));
            chk($sformatf("vec%0d_err", i), 16'(a_err), 16'(vecs[i].err));
        end
        {a_en, a_up, a_clr, a_load, a_lv} = '0;

        // Full mod-60 up count after reset
        rst_n = 1'b0;
        #1;
        chk("rst2_a_q", 16'(a_q), 16'h0000);
        tick();
        rst_n = 1'b1;
        a_en = 1'b1; a_up = 1'b1;
        m = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            chk($sformatf("up60_tc_at%0d", m), 16'(a_tc), 16'(m == 59));
            tick();
            m = (m + 1) % 60;
            chk($sformatf("up60_q_step%0d", k), 16'(a_q), bcd(m));
        end
        a_en = 1'b0;

        // Mod-24 down count from 23
        b_load = 1'b1; b_lv = 8'h23;
        tick();
        chk("m24_load", 16'(b_q), 16'h0023);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
        m = 23;
        for (int k = 0; k < 25; k++) begin
            #1;
            chk($sformatf("m24_tc_at%0d", m), 16'(b_tc), 16'(m == 0));
            tick();
            m = (m + 23) % 24;
            chk($sformatf("m24_q_step%0d", k), 16'(b_q), bcd(m));
        end
        b_en = 1'b0;

        // Three-digit carry and borrow across two nibbles
        c_load = 1'b1; c_lv = 12'h099;
        tick();
        chk("d3_load", 16'(c_q), 16'h0099);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        tick();
        chk("d3_up", 16'(c_q), 16'h0100);
        c_up = 1'b0;
        tick();
        chk("d3_down1", 16'(c_q), 16'h0099);
        tick();
        chk("d3_down2", 16'(c_q), 16'h0098);
        c_en = 1'b0;

        // Cascade 59:59 -> 00:00 on one edge, then async reset mid-count
        l_load = 1'b1; l_lv = 8'h59; h_load = 1'b1; h_lv = 8'h59;
        tick();
        chk("cas_lo_load", 16'(l_q), 16'h0059);
        chk("cas_hi_load", 16'(h_q), 16'h0059);
        l_load = 1'b0; h_load = 1'b0; l_en = 1'b1; l_up = 1'b1;
        #1;
        chk("cas_lo_tc", 16'(l_tc), 16'h0001);
        chk("cas_hi_tc", 16'(h_tc), 16'h0001);
        tick();
        chk("cas_lo_wrap", 16'(l_q), 16'h0000);
        chk("cas_hi_wrap", 16'(h_q), 16'h0000);
        tick();
        tick();
        chk("cas_lo_run", 16'(l_q), 16'h0002);
        chk("cas_hi_run", 16'(h_q), 16'h0000);
        a_load = 1'b1; a_lv = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_lo_q", 16'(l_q), 16'h0000);
        chk("async_hi_q", 16'(h_q), 16'h0000);
        chk("async_c_q", 16'(c_q), 16'h0000);
        chk("async_b_q", 16'(b_q), 16'h0000);
        chk("rst_tc_up", 16'(l_tc), 16'h0000);
        l_up = 1'b0;
        #1;
        chk("rst_tc_down", 16'(l_tc), 16'h0001);
        l_up = 1'b1;
        tick();
        chk("rst_load_err", 16'(a_err), 16'h0000);
        chk("rst_load_q", 16'(a_q), 16'h0000);
        a_load = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_lo", 16'(l_q), 16'h0001);
        chk("post_rst_hi", 16'(h_q), 16'h0000);
        chk("post_rst_err", 16'(a_err), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
